nes_cpu: RTL and testbench



---
 rtl/nes_cpu_if.sv | 10 +
 rtl/nes_cpu.sv | 204 ++++++++++++++++++++
 tb/tb_nes_cpu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_cpu_if.sv
// Read-only memory port of the nes_cpu core: address out, 24-bit instruction/operand window back.
interface nes_cpu_if #(
    parameter int MEM_ADDR_SIZE = 16
);
    logic [MEM_ADDR_SIZE-1:0] mem_addr_o;
    logic [23:0]              mem_data_i;

    modport master (output mem_addr_o, input  mem_data_i);
    modport slave  (input  mem_addr_o, output mem_data_i);
endinterface

// File: rtl/nes_cpu.sv
// Two-cycle (FETCH/EXEC) 6502-subset core: 3-byte fetch window at PC, optional operand read at EA.
module nes_cpu #(
    parameter int          MEM_ADDR_SIZE = 16,
    parameter logic [15:0] RESET_PC      = 16'h0000
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    nes_cpu_if.master mem
);
    typedef enum logic {S_FETCH, S_EXEC} state_t;
    typedef enum logic [2:0] {M_IMPL, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABSX, M_ABSY, M_REL} mode_t;
    typedef enum logic [4:0] {
        O_NOP, O_LDA, O_LDX, O_LDY, O_ADC, O_SBC, O_AND, O_ORA, O_EOR,
        O_INX, O_INY, O_DEX, O_DEY, O_TAX, O_TXA, O_TAY, O_TYA,
        O_CLC, O_SEC, O_JMP, O_BEQ, O_BNE, O_BCS, O_BCC
    } op_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
    logic        c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;
    logic [23:0] ir_q, ir_d;

    op_t         op;
    mode_t       mode;
    logic [7:0]  op1, operand, m_eff, res;
    logic [15:0] abs_w, ea, len, br_target, addr;
    logic [8:0]  sum;
    logic        mem_op, upd_zn;

    assign op1       = ir_q[15:8];
    assign abs_w     = {ir_q[23:16], ir_q[15:8]};
    assign br_target = pc_q + 16'd2 + {{8{op1[7]}}, op1};

    always_comb begin
        op   = O_NOP;
        mode = M_IMPL;
        case (ir_q[7:0])
            8'hA9: begin op = O_LDA; mode = M_IMM;  end
            8'hA5: begin op = O_LDA; mode = M_ZP;   end
            8'hB5: begin op = O_LDA; mode = M_ZPX;  end
            8'hAD: begin op = O_LDA; mode = M_ABS;  end
            8'hBD: begin op = O_LDA; mode = M_ABSX; end
            8'hB9: begin op = O_LDA; mode = M_ABSY; end
            8'hA2: begin op = O_LDX; mode = M_IMM;  end
            8'hA6: begin op = O_LDX; mode = M_ZP;   end
            8'hAE: begin op = O_LDX; mode = M_ABS;  end
            8'hBE: begin op = O_LDX; mode = M_ABSY; end
            8'hA0: begin op = O_LDY; mode = M_IMM;  end
            8'hA4: begin op = O_LDY; mode = M_ZP;   end
            8'hAC: begin op = O_LDY; mode = M_ABS;  end
            8'hBC: begin op = O_LDY; mode = M_ABSX; end
            8'h69: begin op = O_ADC; mode = M_IMM;  end
            8'h65: begin op = O_ADC; mode = M_ZP;   end
            8'h6D: begin op = O_ADC; mode = M_ABS;  end
            8'h7D: begin op = O_ADC; mode = M_ABSX; end
            8'h79: begin op = O_ADC; mode = M_ABSY; end
            8'hE9: begin op = O_SBC; mode = M_IMM;  end
            8'hE5: begin op = O_SBC; mode = M_ZP;   end
            8'hED: begin op = O_SBC; mode = M_ABS;  end
            8'hFD: begin op = O_SBC; mode = M_ABSX; end
            8'hF9: begin op = O_SBC; mode = M_ABSY; end
            8'h29: begin op = O_AND; mode = M_IMM;  end
            8'h25: begin op = O_AND; mode = M_ZP;   end
            8'h2D: begin op = O_AND; mode = M_ABS;  end
            8'h09: begin op = O_ORA; mode = M_IMM;  end
            8'h05: begin op = O_ORA; mode = M_ZP;   end
            8'h0D: begin op = O_ORA; mode = M_ABS;  end
            8'h49: begin op = O_EOR; mode = M_IMM;  end
            8'h45: begin op = O_EOR; mode = M_ZP;   end
            8'h4D: begin op = O_EOR; mode = M_ABS;  end
            8'hE8: op = O_INX;
            8'hC8: op = O_INY;
            8'hCA: op = O_DEX;
            8'h88: op = O_DEY;
            8'hAA: op = O_TAX;
            8'h8A: op = O_TXA;
            8'hA8: op = O_TAY;
            8'h98: op = O_TYA;
            8'h18: op = O_CLC;
            8'h38: op = O_SEC;
            // JMP carries an absolute operand but never reads memory at it
            8'h4C: begin op = O_JMP; mode = M_ABS; end
            8'hF0: begin op = O_BEQ; mode = M_REL; end
            8'hD0: begin op = O_BNE; mode = M_REL; end
            8'hB0: begin op = O_BCS; mode = M_REL; end
            8'h90: begin op = O_BCC; mode = M_REL; end
            default: ;
        endcase
    end

    always_comb begin
        ea     = pc_q;
        mem_op = 1'b1;
        case (mode)
            M_ZP:    ea = {8'h00, op1};
            M_ZPX:   ea = {8'h00, op1 + x_q};
            M_ABS:   ea = abs_w;
            M_ABSX:  ea = abs_w + {8'h00, x_q};
            M_ABSY:  ea = abs_w + {8'h00, y_q};
            default: mem_op = 1'b0;
        endcase
        if (op == O_JMP) mem_op = 1'b0;
        case (mode)
            M_IMPL:                   len = 16'd1;
            M_ABS, M_ABSX, M_ABSY:    len = 16'd3;
            default:                  len = 16'd2;
        endcase
    end

    assign operand = (mode == M_IMM) ? op1 : mem.mem_data_i[7:0];
    assign m_eff   = (op == O_SBC) ? ~operand : operand;
    assign sum     = {1'b0, a_q} + {1'b0, m_eff} + {8'h00, c_q};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        ir_d    = ir_q;
        res     = 8'h00;
        upd_zn  = 1'b0;
        addr    = pc_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = mem.mem_data_i;
                state_d = S_EXEC;
            end
            default: begin
                state_d = S_FETCH;
                if (mem_op) addr = ea;
                pc_d = pc_q + len;
                case (op)
                    O_LDA: begin a_d = operand; res = operand; upd_zn = 1'b1; end
                    O_LDX: begin x_d = operand; res = operand; upd_zn = 1'b1; end
                    O_LDY: begin y_d = operand; res = operand; upd_zn = 1'b1; end
                    O_ADC, O_SBC: begin
                        a_d    = sum[7:0];
                        res    = sum[7:0];
                        c_d    = sum[8];
                        v_d    = (a_q[7] == m_eff[7]) && (sum[7] != a_q[7]);
                        upd_zn = 1'b1;
                    end
                    O_AND: begin res = a_q & operand; a_d = res; upd_zn = 1'b1; end
                    O_ORA: begin res = a_q | operand; a_d = res; upd_zn = 1'b1; end
                    O_EOR: begin res = a_q ^ operand; a_d = res; upd_zn = 1'b1; end
                    O_INX: begin res = x_q + 8'd1; x_d = res; upd_zn = 1'b1; end
                    O_INY: begin res = y_q + 8'd1; y_d = res; upd_zn = 1'b1; end
                    O_DEX: begin res = x_q - 8'd1; x_d = res; upd_zn = 1'b1; end
                    O_DEY: begin res = y_q - 8'd1; y_d = res; upd_zn = 1'b1; end
                    O_TAX: begin res = a_q; x_d = res; upd_zn = 1'b1; end
                    O_TXA: begin res = x_q; a_d = res; upd_zn = 1'b1; end
                    O_TAY: begin res = a_q; y_d = res; upd_zn = 1'b1; end
                    O_TYA: begin res = y_q; a_d = res; upd_zn = 1'b1; end
                    O_CLC: c_d = 1'b0;
                    O_SEC: c_d = 1'b1;
                    O_JMP: pc_d = abs_w;
                    O_BEQ: if (z_q)  pc_d = br_target;
                    O_BNE: if (!z_q) pc_d = br_target;
                    O_BCS: if (c_q)  pc_d = br_target;
                    O_BCC: if (!c_q) pc_d = br_target;
                    default: ;
                endcase
                if (upd_zn) begin
                    z_d = (res == 8'h00);
                    n_d = res[7];
                end
            end
        endcase
    end

    assign mem.mem_addr_o = MEM_ADDR_SIZE'(addr);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            ir_q    <= 24'h000000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_nes_cpu.sv
// Self-checking bench for nes_cpu: directed programs plus random programs against an ISA-level model.
module tb_nes_cpu;
    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    nes_cpu_if #(.MEM_ADDR_SIZE(16)) bus ();
    nes_cpu #(.MEM_ADDR_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .mem    (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0]  mem [0:65535];
    logic [15:0] a0, a1, a2;
    assign a0 = bus.mem_addr_o;
    assign a1 = a0 + 16'd1;
    assign a2 = a0 + 16'd2;
    assign bus.mem_data_i = {mem[a2], mem[a1], mem[a0]};

    int checks = 0;
    int errors = 0;
    int m_pc, m_a, m_x, m_y, m_c, m_z, m_v, m_n;
    int seen;

    int ops [49] = '{8'hA9, 8'hA5, 8'hB5, 8'hAD, 8'hBD, 8'hB9,
                     8'hA2, 8'hA6, 8'hAE, 8'hBE,
                     8'hA0, 8'hA4, 8'hAC, 8'hBC,
                     8'h69, 8'h65, 8'h6D, 8'h7D, 8'h79,
                     8'hE9, 8'hE5, 8'hED, 8'hFD, 8'hF9,
                     8'h29, 8'h25, 8'h2D, 8'h09, 8'h05, 8'h0D, 8'h49, 8'h45, 8'h4D,
                     8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98,
                     8'h18, 8'h38, 8'hEA, 8'h4C,
                     8'hF0, 8'hD0, 8'hB0, 8'h90};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_a = 0; m_x = 0; m_y = 0;
        m_c = 0; m_z = 0; m_v = 0; m_n = 0;
    endfunction

    function automatic void set_zn(input int r);
        m_z = (r == 0) ? 1 : 0;
        m_n = (r >= 128) ? 1 : 0;
    endfunction

    // adds a + m + carry on plain integers; V when both inputs agree in sign and the result does not
    function automatic void add8(input int m);
        int r;
        r   = m_a + m + m_c;
        m_c = (r > 255) ? 1 : 0;
        m_v = (((m_a ^ r) & (m ^ r) & 128) != 0) ? 1 : 0;
        m_a = r & 255;
        set_zn(m_a);
    endfunction

    task automatic load(input int fill, input logic [95:0] bytes, input int n);
        for (int i = 0; i < 65536; i++) mem[i] = 8'(fill);
        for (int i = 0; i < n; i++) mem[i] = bytes[(n-1-i)*8 +: 8];
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        @(negedge clk_i);
        check("rst_addr", int'(bus.mem_addr_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    // Entered and left at a FETCH-cycle falling edge; one instruction per call.
    task automatic run_instr(input string tag, output int exec_seen);
        int op, o1, o2, len, ea, m, absv, next_pc, off;
        bit take;
        check({tag, "/fetch"}, int'(bus.mem_addr_o), m_pc);
        op   = mem[m_pc];
        o1   = mem[(m_pc + 1) & 16'hFFFF];
        o2   = mem[(m_pc + 2) & 16'hFFFF];
        absv = o2 * 256 + o1;
        len  = 1;
        ea   = -1;
        if (op inside {8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49,
                       8'hF0, 8'hD0, 8'hB0, 8'h90}) len = 2;
        if (op inside {8'hA5, 8'hA6, 8'hA4, 8'h65, 8'hE5, 8'h25, 8'h05, 8'h45}) begin
            len = 2; ea = o1;
        end
        if (op == 8'hB5) begin len = 2; ea = (o1 + m_x) % 256; end
        if (op inside {8'hAD, 8'hAE, 8'hAC, 8'h6D, 8'hED, 8'h2D, 8'h0D, 8'h4D}) begin
            len = 3; ea = absv;
        end
        if (op inside {8'hBD, 8'hBC, 8'h7D, 8'hFD}) begin len = 3; ea = (absv + m_x) % 65536; end
        if (op inside {8'hB9, 8'hBE, 8'h79, 8'hF9}) begin len = 3; ea = (absv + m_y) % 65536; end
        if (op == 8'h4C) len = 3;
        m = (ea >= 0) ? int'(mem[ea]) : o1;

        @(negedge clk_i);
        exec_seen = int'(bus.mem_addr_o);
        check({tag, "/exec"}, exec_seen, (ea >= 0) ? ea : m_pc);

        next_pc = (m_pc + len) % 65536;
        if (op inside {8'hA9, 8'hA5, 8'hB5, 8'hAD, 8'hBD, 8'hB9}) begin m_a = m; set_zn(m); end
        if (op inside {8'hA2, 8'hA6, 8'hAE, 8'hBE}) begin m_x = m; set_zn(m); end
        if (op inside {8'hA0, 8'hA4, 8'hAC, 8'hBC}) begin m_y = m; set_zn(m); end
        if (op inside {8'h69, 8'h65, 8'h6D, 8'h7D, 8'h79}) add8(m);
        if (op inside {8'hE9, 8'hE5, 8'hED, 8'hFD, 8'hF9}) add8(255 - m);
        if (op inside {8'h29, 8'h25, 8'h2D}) begin m_a = m_a & m; set_zn(m_a); end
        if (op inside {8'h09, 8'h05, 8'h0D}) begin m_a = m_a | m; set_zn(m_a); end
        if (op inside {8'h49, 8'h45, 8'h4D}) begin m_a = m_a ^ m; set_zn(m_a); end
        case (op)
            8'hE8: begin m_x = (m_x + 1) % 256;   set_zn(m_x); end
            8'hC8: begin m_y = (m_y + 1) % 256;   set_zn(m_y); end
            8'hCA: begin m_x = (m_x + 255) % 256; set_zn(m_x); end
            8'h88: begin m_y = (m_y + 255) % 256; set_zn(m_y); end
            8'hAA: begin m_x = m_a; set_zn(m_x); end
            8'h8A: begin m_a = m_x; set_zn(m_a); end
            8'hA8: begin m_y = m_a; set_zn(m_y); end
            8'h98: begin m_a = m_y; set_zn(m_a); end
            8'h18: m_c = 0;
            8'h38: m_c = 1;
            8'h4C: next_pc = absv;
            default: ;
        endcase
        take = (op == 8'hF0 && m_z == 1) || (op == 8'hD0 && m_z == 0) ||
               (op == 8'hB0 && m_c == 1) || (op == 8'h90 && m_c == 0);
        if (take) begin
            off     = (o1 >= 128) ? o1 - 256 : o1;
            next_pc = (m_pc + 2 + off) & 16'hFFFF;
        end
        m_pc = next_pc;

        @(negedge clk_i);
        check({tag, "/A"}, int'(dut.a_q), m_a);
        check({tag, "/X"}, int'(dut.x_q), m_x);
        check({tag, "/Y"}, int'(dut.y_q), m_y);
        check({tag, "/C"}, int'(dut.c_q), m_c);
        check({tag, "/Z"}, int'(dut.z_q), m_z);
        check({tag, "/V"}, int'(dut.v_q), m_v);
        check({tag, "/N"}, int'(dut.n_q), m_n);
        $display("%s op=%02h next_pc=%04h a=%02h x=%02h y=%02h czvn=%0d%0d%0d%0d",
                 tag, op, m_pc, m_a, m_x, m_y, m_c, m_z, m_v, m_n);
    endtask

    initial begin
        // reset state while rstn_i is held low from time zero
        #1;
        check("rst0_addr", int'(bus.mem_addr_o), 0);
        check("rst0_ir",   int'(dut.ir_q), 0);
        check("rst0_a",    int'(dut.a_q), 0);

        // all-NOP memory: FETCH/EXEC pairs at 0,0,1,1,2,2
        load(8'hEA, 96'h0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) run_instr("nop", seen);
        check("nop_pc", int'(bus.mem_addr_o), 16'h0003);

        // LDX #5 ; LDA $0200,X
        load(8'hEA, 96'hA205BD0002, 5);
        mem[16'h0205] = 8'h7F;
        do_reset();
        run_instr("ldx", seen);
        run_instr("lda_absx", seen);
        check("ldax_ea", seen, 16'h0205);
        check("ldax_a", int'(dut.a_q), 8'h7F);
        check("ldax_next", int'(bus.mem_addr_o), 16'h0005);

        // JMP $1234
        load(8'hEA, 96'h4C3412, 3);
        do_reset();
        run_instr("jmp", seen);
        check("jmp_next", int'(bus.mem_addr_o), 16'h1234);

        // LDA #0 ; BEQ -4 loops, LDA #1 falls through
        load(8'hEA, 96'hA900F0FC, 4);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr("beq_loop", seen);
        check("beq_loop_pc", int'(bus.mem_addr_o), 16'h0000);
        load(8'hEA, 96'hA901F0FC, 4);
        do_reset();
        for (int i = 0; i < 2; i++) run_instr("beq_fall", seen);
        check("beq_fall_pc", int'(bus.mem_addr_o), 16'h0004);

        // CLC ; LDA #FF ; ADC #1/#0 ; BCS +2
        load(8'hEA, 96'h18A9FF6901B002, 7);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr("adc_c1", seen);
        check("adc_c1_pc", int'(bus.mem_addr_o), 16'h0009);
        check("adc_c1_c", int'(dut.c_q), 1);
        check("adc_c1_a", int'(dut.a_q), 0);
        load(8'hEA, 96'h18A9FF6900B002, 7);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr("adc_c0", seen);
        check("adc_c0_pc", int'(bus.mem_addr_o), 16'h0007);
        check("adc_c0_c", int'(dut.c_q), 0);

        // INX wrap to 0 ; BEQ +0
        load(8'hEA, 96'hA2FFE8F000, 5);
        do_reset();
        for (int i = 0; i < 3; i++) run_instr("inx", seen);
        check("inx_x", int'(dut.x_q), 0);
        check("inx_z", int'(dut.z_q), 1);
        check("inx_pc", int'(bus.mem_addr_o), 16'h0005);

        // DEX wrap to FF ; LDA $0100,X
        load(8'hEA, 96'hA200CABD0001, 6);
        do_reset();
        run_instr("dex", seen);
        run_instr("dex", seen);
        check("dex_x", int'(dut.x_q), 8'hFF);
        check("dex_n", int'(dut.n_q), 1);
        run_instr("dex_lda", seen);
        check("dex_ea", seen, 16'h01FF);

        // reset in the middle of an EXEC cycle
        load(8'hEA, 96'hA942AD3412, 5);
        mem[16'h1234] = 8'h99;
        do_reset();
        run_instr("mid", seen);
        @(posedge clk_i);
        #2;
        check("mid_exec_addr", int'(bus.mem_addr_o), 16'h1234);
        rstn_i = 1'b0;
        #1;
        check("mid_async_addr", int'(bus.mem_addr_o), 0);
        check("mid_async_a", int'(dut.a_q), 0);
        @(posedge clk_i);
        #1;
        check("mid_hold_a", int'(dut.a_q), 0);
        check("mid_hold_addr", int'(bus.mem_addr_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
        run_instr("mid_after", seen);
        check("mid_after_a", int'(dut.a_q), 8'h42);

        // random programs against the model
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 65536; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'(ops[$urandom_range(0, 48)]);
            do_reset();
            for (int i = 0; i < 300; i++) run_instr("rnd", seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
